// File: rtl/pong_pkg.sv
// Shared pong constants, the AI paddle state type and a y-range clamp helper.
package pong_pkg;

  localparam int DEF_TOP_BOUNDARY    = 3;
  localparam int DEF_BOTTOM_BOUNDARY = 477;
  localparam int DEF_PADDLE_HEIGHT   = 46;
  localparam int DEF_START_Y         = 217;
  localparam int DEF_PLAYER_STEP     = 4;
  localparam int DEF_AI_STEP         = 3;
  localparam int DEF_AI_DEADZONE     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  typedef enum logic {
    HOME  = 1'b0,
    TRACK = 1'b1
  } ai_state_t;

  // Saturate an 11-bit signed position into [lo, hi]; result is a 10-bit screen y.
  function automatic logic [9:0] clamp_y(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
    logic signed [10:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r[9:0];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_level;

  assign sync_level = ~sync_q[1];

  // The counter tracks how long the synchronized level has disagreed with the
  // accepted level; any agreement restarts it.
  always_comb begin
    sync_d  = {sync_q[0], button_n};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_level != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_level;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Player and AI paddle position generator for pong.
// Define PADDLE_AI_EN to build the ball-tracking AI; otherwise the right paddle is fixed at START_Y.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int TOP_BOUNDARY    = DEF_TOP_BOUNDARY,
  parameter int BOTTOM_BOUNDARY = DEF_BOTTOM_BOUNDARY,
  parameter int PADDLE_HEIGHT   = DEF_PADDLE_HEIGHT,
  parameter int START_Y         = DEF_START_Y,
  parameter int PLAYER_STEP     = DEF_PLAYER_STEP,
  parameter int AI_STEP         = DEF_AI_STEP,
  parameter int AI_DEADZONE     = DEF_AI_DEADZONE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       button_up_n,
  input  logic       button_down_n,
  input  logic [9:0] ball_y,
  input  logic       ball_dir_right,
  output logic [9:0] left_paddle_y,
  output logic [9:0] right_paddle_y,
  output logic       ai_state_dbg
);

  localparam logic signed [10:0] Y_MIN  = 11'(TOP_BOUNDARY);
  localparam logic signed [10:0] Y_MAX  = 11'(BOTTOM_BOUNDARY - PADDLE_HEIGHT);
  localparam logic signed [10:0] P_STEP = 11'(PLAYER_STEP);
  localparam logic [9:0]         Y_HOME = 10'(START_Y);

  logic up_pressed, down_pressed;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk      (clk),
    .reset_n  (reset_n),
    .button_n (button_up_n),
    .pressed  (up_pressed)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk      (clk),
    .reset_n  (reset_n),
    .button_n (button_down_n),
    .pressed  (down_pressed)
  );

  // Player paddle: one step per tick, conflicting buttons cancel out.
  logic [9:0]         left_q, left_d;
  logic signed [10:0] left_sum;

  always_comb begin
    left_d   = left_q;
    left_sum = $signed({1'b0, left_q});
    if (up_pressed && !down_pressed) begin
      left_sum = $signed({1'b0, left_q}) - P_STEP;
    end else if (down_pressed && !up_pressed) begin
      left_sum = $signed({1'b0, left_q}) + P_STEP;
    end
    if (tick) begin
      left_d = clamp_y(left_sum, Y_MIN, Y_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q <= Y_HOME;
    end else begin
      left_q <= left_d;
    end
  end

  assign left_paddle_y = left_q;

`ifdef PADDLE_AI_EN
  localparam logic signed [10:0] A_STEP = 11'(AI_STEP);
  localparam logic signed [10:0] A_DZ   = 11'(AI_DEADZONE);
  localparam logic signed [10:0] HALF_H = 11'(PADDLE_HEIGHT / 2);
  localparam logic signed [10:0] A_HOME = 11'(START_Y);

  ai_state_t          state_q, state_d;
  logic [9:0]         right_q, right_d;
  logic signed [10:0] target, err, err_abs, step, right_s;
  logic               in_deadzone;

  // The move on a tick uses state_q, so a same-cycle transition still moves toward the old target.
  always_comb begin
    state_d = ball_dir_right ? TRACK : HOME;
    right_d = right_q;
    target  = A_HOME;
    if (state_q == TRACK) begin
      target = $signed({1'b0, clamp_y($signed({1'b0, ball_y}) - HALF_H, Y_MIN, Y_MAX)});
    end
    err         = target - $signed({1'b0, right_q});
    err_abs     = err[10] ? -err : err;
    step        = (err_abs > A_STEP) ? A_STEP : err_abs;
    right_s     = err[10] ? $signed({1'b0, right_q}) - step
                          : $signed({1'b0, right_q}) + step;
    in_deadzone = (state_q == TRACK) && (err_abs <= A_DZ);
    if (tick && (err_abs != 11'sd0) && !in_deadzone) begin
      right_d = clamp_y(right_s, Y_MIN, Y_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOME;
      right_q <= Y_HOME;
    end else begin
      state_q <= state_d;
      right_q <= right_d;
    end
  end

  assign right_paddle_y = right_q;
  assign ai_state_dbg   = state_q;
`else
  logic unused_ai_inputs;
  assign unused_ai_inputs = ^{ball_y, ball_dir_right, 32'(AI_STEP), 32'(AI_DEADZONE)};
  assign right_paddle_y   = Y_HOME;
  assign ai_state_dbg     = 1'b0;
`endif

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: a reference model of paddle motion checked every cycle,
// plus literal expectations at key points of the stimulus.
module tb_paddle_ctrl;

  localparam int DB     = 16;
  localparam int Y_LO   = 3;
  localparam int Y_HI   = 431;
  localparam int Y_HOME = 217;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       button_up_n = 1'b1;
  logic       button_down_n = 1'b1;
  logic [9:0] ball_y = '0;
  logic       ball_dir_right = 1'b0;
  logic [9:0] left_paddle_y, right_paddle_y;
  logic       ai_state_dbg;

  int checks = 0;
  int errors = 0;

`ifdef PADDLE_AI_EN
  localparam bit AI_ON = 1'b1;
`else
  localparam bit AI_ON = 1'b0;
`endif

  paddle_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tick           (tick),
    .button_up_n    (button_up_n),
    .button_down_n  (button_down_n),
    .ball_y         (ball_y),
    .ball_dir_right (ball_dir_right),
    .left_paddle_y  (left_paddle_y),
    .right_paddle_y (right_paddle_y),
    .ai_state_dbg   (ai_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_left, m_right;
  bit m_track;
  bit m_up_db, m_dn_db;
  bit h_up[DB+2];
  bit h_dn[DB+2];

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  // A raw level is accepted once it has been seen for DB consecutive samples, two samples late.
  function automatic bit run_of(input bit h[DB+2], input bit v);
    for (int i = 2; i < DB + 2; i++) if (h[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = Y_HOME; m_right = Y_HOME; m_track = 1'b0;
      m_up_db = 1'b0; m_dn_db = 1'b0;
      for (int i = 0; i < DB + 2; i++) begin h_up[i] = 1'b0; h_dn[i] = 1'b0; end
    end else begin
      if (tick) begin
        if (m_up_db && !m_dn_db) m_left = imax(m_left - 4, Y_LO);
        else if (m_dn_db && !m_up_db) m_left = imin(m_left + 4, Y_HI);
        if (AI_ON) begin
          int tgt, e, ae;
          tgt = m_track ? imin(imax(int'(ball_y) - 23, Y_LO), Y_HI) : Y_HOME;
          e = tgt - m_right;
          ae = (e < 0) ? -e : e;
          if (!(m_track && ae <= 2) && ae != 0)
            m_right = m_right + ((e < 0) ? -imin(3, ae) : imin(3, ae));
        end
      end
      if (AI_ON) m_track = ball_dir_right;
      for (int i = DB + 1; i > 0; i--) begin h_up[i] = h_up[i-1]; h_dn[i] = h_dn[i-1]; end
      h_up[0] = !button_up_n;
      h_dn[0] = !button_down_n;
      if (run_of(h_up, !m_up_db)) m_up_db = !m_up_db;
      if (run_of(h_dn, !m_dn_db)) m_dn_db = !m_dn_db;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("left_model", int'(left_paddle_y), m_left);
      check("right_model", int'(right_paddle_y), m_right);
      check("state_model", int'(ai_state_dbg), int'(m_track));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wait_cycles(3);
    check("reset_left", int'(left_paddle_y), 217);
    check("reset_right", int'(right_paddle_y), 217);
    check("reset_state", int'(ai_state_dbg), 0);
    reset_n = 1'b1;
    wait_cycles(2);

    // up press, 5 ticks
    button_up_n = 1'b0;
    wait_cycles(20);
    do_tick(5);
    check("up_5_ticks", int'(left_paddle_y), 197);
    do_tick(48);
    check("up_to_5", int'(left_paddle_y), 5);
    do_tick(1);
    check("up_clamp_3", int'(left_paddle_y), 3);
    do_tick(3);
    check("up_hold_3", int'(left_paddle_y), 3);

    // down to bottom boundary
    button_up_n = 1'b1;
    wait_cycles(20);
    button_down_n = 1'b0;
    wait_cycles(20);
    do_tick(106);
    check("down_to_427", int'(left_paddle_y), 427);
    do_tick(2);
    check("down_clamp_431", int'(left_paddle_y), 431);
    do_tick(2);
    check("down_hold_431", int'(left_paddle_y), 431);
    button_down_n = 1'b1;
    wait_cycles(20);

    // short glitch is rejected
    button_up_n = 1'b0;
    wait_cycles(10);
    button_up_n = 1'b1;
    wait_cycles(8);
    do_tick(1);
    check("glitch_no_move", int'(left_paddle_y), 431);

    // both buttons cancel
    button_up_n = 1'b0;
    button_down_n = 1'b0;
    wait_cycles(20);
    do_tick(2);
    check("both_no_move", int'(left_paddle_y), 431);
    button_up_n = 1'b1;
    button_down_n = 1'b1;
    wait_cycles(20);

    // AI tracking
    ball_y = 10'd100;
    ball_dir_right = 1'b1;
    wait_cycles(1);
    do_tick(1);
    check("ai_first_step", int'(right_paddle_y), AI_ON ? 214 : 217);
    do_tick(50);
    check("ai_converge", int'(right_paddle_y), AI_ON ? 79 : 217);

    // AI homing
    ball_dir_right = 1'b0;
    wait_cycles(1);
    do_tick(46);
    check("ai_home", int'(right_paddle_y), 217);
    do_tick(3);
    check("ai_home_hold", int'(right_paddle_y), 217);

    // tick coincident with a state change uses the previous target
    ball_y = 10'd500;
    ball_dir_right = 1'b1;
    do_tick(1);
    check("same_cycle_home", int'(right_paddle_y), 217);
    do_tick(1);
    check("track_bottom", int'(right_paddle_y), AI_ON ? 220 : 217);
    ball_dir_right = 1'b0;
    do_tick(1);
    check("same_cycle_track", int'(right_paddle_y), AI_ON ? 223 : 217);
    do_tick(2);
    check("home_again", int'(right_paddle_y), 217);

    // asynchronous reset mid-run
    button_up_n = 1'b0;
    ball_y = 10'd30;
    ball_dir_right = 1'b1;
    wait_cycles(20);
    do_tick(3);
    check("pre_reset_left", int'(left_paddle_y), 419);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_left", int'(left_paddle_y), 217);
    check("async_reset_right", int'(right_paddle_y), 217);
    check("async_reset_state", int'(ai_state_dbg), 0);
    button_up_n = 1'b1;
    ball_dir_right = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(5);
    check("post_reset_left", int'(left_paddle_y), 217);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
